// File: rtl/apb_event_scheduler.sv
// APB event scheduler: latches three event sources, arbitrates them round-robin
// and issues one APB write per event, aborting an ACCESS that stalls for 16 cycles.
module apb_event_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  event_i,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    input  logic        pready_i,
    output logic        busy_o,
    output logic [2:0]  drop_o,
    output logic        err_o,
    output logic [2:0]  pending_o
);
    localparam int unsigned NSRC = 3;
    localparam int unsigned SEQW = 8;
    localparam int unsigned TMOW = 4;
    localparam int unsigned AW   = 32;
    localparam logic [1:0]  SRC_C = 2'd2;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                      state_q, state_d;
    logic [1:0]                  grant_q, grant_d;
    logic [1:0]                  last_q, last_d;
    logic [TMOW-1:0]             tmo_q, tmo_d;
    logic [NSRC-1:0]             pending_q, pending_d;
    logic [NSRC-1:0][SEQW-1:0]   seq_q, seq_d;
    logic [NSRC-1:0]             drop_q, drop_d;
    logic                        err_q, err_d;
    logic                        psel_q, psel_d;
    logic                        penable_q, penable_d;
    logic [AW-1:0]               paddr_q, paddr_d;
    logic [AW-1:0]               pwdata_q, pwdata_d;
    logic [NSRC-1:0]             req, req_rest;
    logic                        complete;

    // First requesting source strictly after 'last', wrapping a->b->c->a.
    function automatic logic [1:0] rr_pick(input logic [NSRC-1:0] r, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            idx = 2'((int'(last) + i) % 3);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [1:0] g);
        case (g)
            2'd0:    addr_of = 32'h1000_1000;
            2'd1:    addr_of = 32'h2000_2000;
            default: addr_of = 32'h3000_3000;
        endcase
    endfunction

    assign req      = pending_q | event_i;
    assign req_rest = req & ~(3'b001 << grant_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        tmo_d     = tmo_q;
        seq_d     = seq_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pending_d = pending_q | event_i;
        err_d     = 1'b0;
        complete  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    state_d = SETUP;
                    grant_d = rr_pick(req, last_q);
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready_i) begin
                    complete           = 1'b1;
                    pending_d[grant_q] = event_i[grant_q];
                    seq_d[grant_q]     = seq_q[grant_q] + 8'd1;
                    last_d             = grant_q;
                    if (req_rest != '0) begin
                        state_d = SETUP;
                        grant_d = rr_pick(req_rest, grant_q);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo_q == 4'hF) begin
                    // Abort keeps the event pending but lets other sources go first.
                    state_d = IDLE;
                    err_d   = 1'b1;
                    last_d  = grant_q;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Latch the bus payload only when a new transfer begins.
        if (state_d == SETUP) begin
            tmo_d    = '0;
            paddr_d  = addr_of(grant_d);
            pwdata_d = {16'hCAFE, 6'b0, grant_d, seq_q[grant_d]};
        end

        drop_d = event_i & pending_q;
        if (complete) begin
            drop_d[grant_q] = 1'b0;
        end

        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= SRC_C;
            last_q    <= SRC_C;
            tmo_q     <= '0;
            pending_q <= '0;
            seq_q     <= '0;
            drop_q    <= '0;
            err_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            tmo_q     <= tmo_d;
            pending_q <= pending_d;
            seq_q     <= seq_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = psel_q;
    assign busy_o    = psel_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign drop_o    = drop_q;
    assign err_o     = err_q;
    assign pending_o = pending_q;
endmodule

// File: tb/tb_apb_event_scheduler.sv
// Scoreboard bench for apb_event_scheduler: expected APB writes are queued as
// events are driven and popped when the DUT completes a transfer.
module tb_apb_event_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  event_i;
    logic        pready_i;
    logic        psel_o, penable_o, pwrite_o, busy_o, err_o;
    logic [31:0] paddr_o, pwdata_o;
    logic [2:0]  drop_o, pending_o;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  exp_seq[3];
    logic [63:0] mon_got, mon_exp;

    apb_event_scheduler dut (
        .clk(clk), .rst(rst), .event_i(event_i),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pready_i(pready_i),
        .busy_o(busy_o), .drop_o(drop_o), .err_o(err_o), .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addr_of(input int s);
        case (s)
            0:       addr_of = 32'h1000_1000;
            1:       addr_of = 32'h2000_2000;
            default: addr_of = 32'h3000_3000;
        endcase
    endfunction

    task automatic push_exp(input int s);
        exp_q.push_back({addr_of(s), 16'hCAFE, 6'b0, 2'(s), exp_seq[s]});
        exp_seq[s] = exp_seq[s] + 8'd1;
    endtask

    // Completion happens at the next rising edge when these are seen at the falling edge.
    always @(negedge clk) begin
        if (rst && psel_o && penable_o && pready_i) begin
            mon_got = {paddr_o, pwdata_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_xfer got=%h required=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp || pwrite_o !== 1'b1) begin
                    errors++;
                    $display("FAIL xfer got=%h pwrite=%b required=%h pwrite=1", mon_got, pwrite_o, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] e);
        event_i = e;
        step();
        event_i = 3'b000;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(psel_o == 1'b0 && pending_o == 3'b000 && exp_q.size() == 0) && n < max);
        checks++;
        if (psel_o !== 1'b0 || pending_o !== 3'b000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wait_idle psel=%b pending=%b queued=%0d required psel=0 pending=000 queued=0",
                     psel_o, pending_o, exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        event_i = 3'b000;
        pready_i = 1'b1;
        exp_q.delete();
        exp_seq = '{default: 8'h00};
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        event_i = 3'b000;
        pready_i = 1'b1;
        #2;
        checks++;
        if ({psel_o, penable_o, pwrite_o, busy_o, err_o} !== 5'b0 || drop_o !== 3'b0 || pending_o !== 3'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b%b%b%b%b drop=%b pend=%b required all 0",
                     psel_o, penable_o, pwrite_o, busy_o, err_o, drop_o, pending_o);
        end
        checks++;
        if (paddr_o !== 32'h0 || pwdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got=%h/%h required=0/0", paddr_o, pwdata_o);
        end
        do_reset();
    endtask

    task automatic test_single();
        push_exp(0);
        pulse(3'b001);
        checks++;
        if (psel_o !== 1'b1 || penable_o !== 1'b0 || busy_o !== 1'b1 || pwrite_o !== 1'b1) begin
            errors++;
            $display("FAIL single_setup got psel=%b pen=%b busy=%b pw=%b required 1 0 1 1", psel_o, penable_o, busy_o, pwrite_o);
        end
        checks++;
        if (paddr_o !== 32'h1000_1000 || pwdata_o !== 32'hCAFE_0000) begin
            errors++;
            $display("FAIL single_bus got=%h/%h required=10001000/cafe0000", paddr_o, pwdata_o);
        end
        step();
        checks++;
        if (psel_o !== 1'b1 || penable_o !== 1'b1) begin
            errors++;
            $display("FAIL single_access got psel=%b pen=%b required 1 1", psel_o, penable_o);
        end
        step();
        checks++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0 || pending_o !== 3'b000) begin
            errors++;
            $display("FAIL single_idle got psel=%b pen=%b pend=%b required 0 0 000", psel_o, penable_o, pending_o);
        end
    endtask

    task automatic test_simultaneous();
        push_exp(0);
        push_exp(1);
        push_exp(2);
        pulse(3'b111);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (psel_o !== 1'b1 || penable_o !== ((i % 2) == 1)) begin
                errors++;
                $display("FAIL b2b_phase%0d got psel=%b pen=%b required 1 %0d", i, psel_o, penable_o, i % 2);
            end
            step();
        end
        checks++;
        if (psel_o !== 1'b0 || pending_o !== 3'b000) begin
            errors++;
            $display("FAIL b2b_end got psel=%b pend=%b required 0 000", psel_o, pending_o);
        end
    endtask

    task automatic test_round_robin();
        push_exp(1);
        pulse(3'b010);
        wait_idle(10);
        push_exp(2);
        push_exp(0);
        pulse(3'b101);
        checks++;
        if (paddr_o !== 32'h3000_3000) begin
            errors++;
            $display("FAIL rr_first got=%h required=30003000", paddr_o);
        end
        wait_idle(12);
    endtask

    task automatic test_drop();
        pready_i = 1'b0;
        push_exp(0);
        pulse(3'b001);
        step();
        event_i = 3'b001;
        step();
        event_i = 3'b000;
        checks++;
        if (drop_o !== 3'b001 || pending_o !== 3'b001) begin
            errors++;
            $display("FAIL drop_pulse got drop=%b pend=%b required 001 001", drop_o, pending_o);
        end
        step();
        checks++;
        if (drop_o !== 3'b000) begin
            errors++;
            $display("FAIL drop_clear got=%b required=000", drop_o);
        end
        pready_i = 1'b1;
        wait_idle(10);
        repeat (3) step();
        checks++;
        if (psel_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_extra got psel=%b required 0", psel_o);
        end
    endtask

    task automatic test_event_on_complete();
        push_exp(0);
        push_exp(0);
        pulse(3'b001);
        step();
        event_i = 3'b001;
        step();
        event_i = 3'b000;
        checks++;
        if (drop_o !== 3'b000 || pending_o !== 3'b001) begin
            errors++;
            $display("FAIL complete_evt got drop=%b pend=%b required 000 001", drop_o, pending_o);
        end
        wait_idle(12);
    endtask

    task automatic test_timeout();
        pready_i = 1'b0;
        push_exp(1);
        pulse(3'b010);
        step();
        repeat (15) step();
        checks++;
        if (psel_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early got psel=%b err=%b required 1 0", psel_o, err_o);
        end
        step();
        checks++;
        if (psel_o !== 1'b0 || err_o !== 1'b1 || pending_o !== 3'b010) begin
            errors++;
            $display("FAIL tmo_abort got psel=%b err=%b pend=%b required 0 1 010", psel_o, err_o, pending_o);
        end
        pready_i = 1'b1;
        step();
        checks++;
        if (err_o !== 1'b0 || psel_o !== 1'b1) begin
            errors++;
            $display("FAIL tmo_retry got err=%b psel=%b required 0 1", err_o, psel_o);
        end
        wait_idle(10);
    endtask

    task automatic test_reset_mid();
        pready_i = 1'b0;
        pulse(3'b001);
        step();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0 || busy_o !== 1'b0 || pending_o !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid got psel=%b pen=%b busy=%b pend=%b required 0 0 0 000", psel_o, penable_o, busy_o, pending_o);
        end
        exp_q.delete();
        exp_seq = '{default: 8'h00};
        @(negedge clk);
        rst = 1'b1;
        event_i = 3'b001;
        pready_i = 1'b1;
        push_exp(0);
        step();
        event_i = 3'b000;
        checks++;
        if (psel_o !== 1'b1 || pwdata_o !== 32'hCAFE_0000) begin
            errors++;
            $display("FAIL reset_first got psel=%b data=%h required 1 cafe0000", psel_o, pwdata_o);
        end
        wait_idle(10);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            push_exp(2);
            pulse(3'b100);
            wait_idle(10);
        end
        push_exp(2);
        pulse(3'b100);
        checks++;
        if (pwdata_o !== 32'hCAFE_0200) begin
            errors++;
            $display("FAIL wrap got=%h required=cafe0200", pwdata_o);
        end
        wait_idle(10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        do_reset();
        test_simultaneous();
        test_round_robin();
        test_drop();
        test_event_on_complete();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/apb_event_scheduler.md
APB_EVENT_SCHEDULER -- requirements
Module: apb_event_scheduler

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; all flops clocked on it.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: event_i  in  3  event pulses; bit0=a, bit1=b, bit2=c.
REQ-004 SHALL have: psel_o, penable_o, pwrite_o  out  1 each  APB control.
REQ-005 SHALL have: paddr_o, pwdata_o  out  32 each  APB address and write data.
REQ-006 SHALL have: pready_i  in  1  APB slave ready.
REQ-007 SHALL have: busy_o  out  1  high in SETUP or ACCESS.
REQ-008 SHALL have: drop_o  out  3  one-cycle pulse per source when an event is lost.
REQ-009 SHALL have: err_o  out  1  one-cycle pulse on an ACCESS timeout abort.
REQ-010 SHALL have: pending_o  out  3  current pending flags.

Function
REQ-011 SHALL register every output; no combinational path from an input to an output.
REQ-012 SHALL hold a pending flag per source; event_i[k]=1 at a clock edge sets pending[k].
REQ-013 SHALL form the request vector req = pending | event_i.
REQ-014 SHALL arbitrate req round-robin, starting from the source after last_grant; the reset value of last_grant is c, so a>b>c initially.
REQ-015 SHALL use a three-state FSM: IDLE, SETUP (psel=1, penable=0), ACCESS (psel=1, penable=1).
REQ-016 IDLE with req!=0 SHALL move to SETUP at the next edge, latching the grant, paddr and pwdata; event_i high in cycle 0 gives psel_o=1 in cycle 1.
REQ-017 SHALL drive paddr per grant: a=32'h1000_1000, b=32'h2000_2000, c=32'h3000_3000; pwrite_o=1 in SETUP and ACCESS.
REQ-018 SHALL drive pwdata = {16'hCAFE, 6'b0, src[1:0], seq[k][7:0]}, where seq[k] is an 8-bit per-source counter.
REQ-019 SETUP SHALL always move to ACCESS after exactly one cycle.
REQ-020 ACCESS with pready_i=1 completes the transfer and SHALL:
  - clear pending[grant];
  - increment seq[grant], wrapping 255->0;
  - set last_grant=grant.
REQ-021 On completion, if req (excluding the cleared source) is non-zero, SHALL go directly to SETUP with no IDLE cycle; otherwise go to IDLE with psel_o=0 and penable_o=0.
REQ-022 If event_i[grant]=1 in the completion cycle, pending[grant] SHALL remain set, counted as a new event, with no drop.
REQ-023 If event_i[k]=1 while pending[k]=1 and k is not completing, SHALL pulse drop_o[k] for one cycle and leave pending[k] unchanged.
REQ-024 SHALL hold paddr_o, pwdata_o and pwrite_o stable from SETUP through ACCESS completion.
REQ-025 SHALL count ACCESS cycles with pready_i=0 in a 4-bit counter, cleared on entry to SETUP.
REQ-026 After 16 consecutive ACCESS cycles with pready_i=0, SHALL:
  - abort to IDLE, psel_o=0;
  - pulse err_o for one cycle;
  - keep pending[grant] set and seq[grant] unchanged;
  - set last_grant=grant so other sources get the next turn.
REQ-027 SHALL never sample or change the grant outside IDLE or a completion/abort edge.

Reset
REQ-028 While rst=0, SHALL asynchronously force:
  - psel_o, penable_o, pwrite_o, busy_o, err_o = 0;
  - drop_o, pending = 3'b000;
  - paddr_o, pwdata_o = 0;
  - seq = 0; timeout counter = 0; last_grant = c; state = IDLE.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer with no completion side effects.
REQ-030 After reset release, events SHALL be honoured from the first rising edge.

Verification
REQ-031 Single event: event_i=001 pulse, pready_i=1 -> psel_o=1 in cycle 1, penable_o=1 in cycle 2, paddr_o=1000_1000, pwdata_o=CAFE_0000, then IDLE.
REQ-032 Simultaneous events: event_i=111 pulse -> three back-to-back transfers in order a, b, c (SETUP/ACCESS pairs, no IDLE between); end with pending_o=000.
REQ-033 Round-robin: b granted last, then a and c both pending -> c is served before a.
REQ-034 Drop: a held pending under a stalled pready_i, second a pulse -> drop_o=001 for one cycle; only one transfer to a occurs.
REQ-035 Timeout: pready_i=0 for 16 ACCESS cycles -> err_o pulse, psel_o=0, pending_o keeps the bit; retry succeeds with an unchanged seq value.
REQ-036 Wrap: 256 completions on c -> pwdata_o low byte returns to 8'h00, upper bits = CAFE_02.
